// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT result-memory consumers.
package fft_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int L         = 9;
  localparam int N         = 1 << L;
  localparam int HALF_N    = N / 2;

  // Bin-reader sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } rdr_state_t;

  // One result-RAM word: {re, im}, each signed Q1.15
  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] re;
    logic signed [BIT_WIDTH-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_bin_reader_if.sv
// Result-RAM read port plus the {bin, magnitude} valid/ready stream.
interface fft_bin_reader_if #(
  parameter int dw = fft_pkg::BIT_WIDTH,
  parameter int aw = fft_pkg::L
);
  import fft_pkg::*;

  logic [aw-1:0]   rd_addr;
  logic [2*dw-1:0] rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [aw-1:0]   out_bin;
  logic [2*dw-1:0] out_mag;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_bin,
    output out_mag
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_bin,
    input  out_mag
  );
endinterface

// File: rtl/fft_bin_reader_mag_sq.sv
// Exact squared magnitude re^2 + im^2 of a signed complex sample.
module mag_sq #(
  parameter int bit_width = 16
) (
  input  logic signed [bit_width-1:0]   re,
  input  logic signed [bit_width-1:0]   im,
  output logic        [2*bit_width-1:0] mag
);
  import fft_pkg::*;

  logic signed [2*bit_width-1:0] re_x, im_x, re_sq, im_sq;

  // Sign-extend before squaring so the full-width product is exact.
  assign re_x  = {{bit_width{re[bit_width-1]}}, re};
  assign im_x  = {{bit_width{im[bit_width-1]}}, im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  // Both squares are non-negative and at most 2^30, so the unsigned sum
  // (at most 2^31) fits without overflow.
  assign mag = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_bin_reader.sv
// Sweeps FFT bins 0..N/2-1, streams {bin, |X|^2} and tracks the non-DC peak.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start from the FFT core
// ISSUE | rd_addr holds the current bin; RAM samples it this cycle
// WAIT  | rd_data valid; register magnitude and bin
// SEND  | out_valid high until accepted; peak update on handshake
// DONE  | one-cycle done pulse
module fft_bin_reader #(
  parameter int bit_width = 16,
  parameter int L         = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  fft_bin_reader_if.master       bus,
  output logic [L-1:0]           peak_bin,
  output logic [2*bit_width-1:0] peak_mag,
  output logic                   busy,
  output logic                   done
);
  import fft_pkg::*;

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] ISSUE = ST_ISSUE;
  localparam logic [2:0] WAIT  = ST_WAIT;
  localparam logic [2:0] SEND  = ST_SEND;
  localparam logic [2:0] DONE  = ST_DONE;

  localparam logic [L-1:0] LAST_BIN = L'((1 << (L - 1)) - 1);

  logic [2:0]             state;
  logic [L-1:0]           cnt;
  logic [2*bit_width-1:0] mag;
  logic                   handshake;

  mag_sq #(.bit_width(bit_width)) u_mag_sq (
    .re  (bus.rd_data[2*bit_width-1:bit_width]),
    .im  (bus.rd_data[bit_width-1:0]),
    .mag (mag)
  );

  // Status outputs decode directly from the state register.
  assign bus.out_valid = (state == SEND);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign handshake     = bus.out_valid && bus.out_ready;

  // Sequencer, bin counter, output and peak registers.
  // rd_addr is loaded on entry to ISSUE so the RAM sees the bin address
  // for the whole ISSUE cycle and returns data in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.rd_addr <= '0;
      bus.out_bin <= '0;
      bus.out_mag <= '0;
      peak_bin    <= '0;
      peak_mag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            bus.rd_addr <= '0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          bus.out_mag <= mag;
          bus.out_bin <= cnt;
          state       <= SEND;
        end
        SEND: begin
          if (handshake) begin
            // Strict compare keeps the lower bin on ties; DC never wins.
            if (bus.out_bin != '0 && bus.out_mag > peak_mag) begin
              peak_bin <= bus.out_bin;
              peak_mag <= bus.out_mag;
            end
            if (bus.out_bin == LAST_BIN) begin
              state <= DONE;
            end else begin
              cnt         <= cnt + 1'b1;
              bus.rd_addr <= cnt + 1'b1;
              state       <= ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
